// File: rtl/fc_sched_pkg.sv
// Shared definitions for the FC frame scheduler.
// Holds the default frame geometry, the watchdog limit, the derived counter
// widths and the control state encoding used by fc_frame_scheduler.
package fc_sched_pkg;

    localparam int IN_DIM_DEF  = 32;
    localparam int OUT_DIM_DEF = 10;
    localparam int TIMEOUT_DEF = 64;

    localparam int IDX_W_DEF = $clog2(IN_DIM_DEF);
    localparam int LG_W_DEF  = $clog2(OUT_DIM_DEF + 1);
    localparam int WD_W_DEF  = $clog2(TIMEOUT_DEF + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2,
        S_HOLD   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/fc_pingpong_buf.sv
// Two-bank (ping-pong) frame buffer, IN_DIM bytes per bank.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_valid     upstream byte present
//   wr_data      upstream byte
//   wr_ready     registered; high when the current write bank is empty
//   rd_en        read request for rd_addr in the current read bank
//   rd_addr      byte index within the read bank
//   rd_data      registered read data (0 when rd_en was low)
//   rd_full      current read bank holds a complete frame
//   rd_free      marks the read bank empty and toggles to the other bank
module fc_pingpong_buf
    import fc_sched_pkg::*;
#(
    parameter int IN_DIM = IN_DIM_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid,
    input  logic [7:0]                wr_data,
    output logic                      wr_ready,
    input  logic                      rd_en,
    input  logic [$clog2(IN_DIM)-1:0] rd_addr,
    output logic [7:0]                rd_data,
    output logic                      rd_full,
    input  logic                      rd_free
);

    localparam int IDX_W = $clog2(IN_DIM);

    logic [7:0]       mem_r [2][IN_DIM];
    logic [1:0]       full_r;
    logic [1:0]       full_nxt_s;
    logic             wr_bank_r;
    logic             wr_bank_nxt_s;
    logic [IDX_W-1:0] wr_idx_r;
    logic [IDX_W-1:0] wr_idx_nxt_s;
    logic             wr_ready_r;
    logic             rd_bank_r;
    logic [7:0]       rd_data_r;
    logic             wr_fire_s;
    logic             wr_last_s;

    // Write-side bookkeeping: bank fill index, full flags, bank toggling.
    always_comb begin
        wr_fire_s     = wr_valid & wr_ready_r;
        wr_last_s     = wr_fire_s & (wr_idx_r == IDX_W'(IN_DIM - 1));
        wr_bank_nxt_s = wr_bank_r;
        wr_idx_nxt_s  = wr_idx_r;
        if (wr_last_s) begin
            wr_bank_nxt_s = ~wr_bank_r;
            wr_idx_nxt_s  = IDX_W'(0);
        end else if (wr_fire_s) begin
            wr_idx_nxt_s  = wr_idx_r + IDX_W'(1);
        end else begin
            wr_idx_nxt_s  = wr_idx_r;
        end
        // The writer only completes an empty bank and the reader only frees a
        // full one, so set and clear never target the same bank.
        for (int b = 0; b < 2; b++) begin
            full_nxt_s[b] = (full_r[b] | (wr_last_s & (wr_bank_r == 1'(b))))
                            & ~(rd_free & (rd_bank_r == 1'(b)));
        end
    end

    // Control registers; wr_ready is registered from next-state so it stays
    // low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r     <= 2'b00;
            wr_bank_r  <= 1'b0;
            wr_idx_r   <= IDX_W'(0);
            wr_ready_r <= 1'b0;
            rd_bank_r  <= 1'b0;
            rd_data_r  <= 8'd0;
        end else begin
            full_r     <= full_nxt_s;
            wr_bank_r  <= wr_bank_nxt_s;
            wr_idx_r   <= wr_idx_nxt_s;
            wr_ready_r <= ~full_nxt_s[wr_bank_nxt_s];
            rd_bank_r  <= rd_free ? ~rd_bank_r : rd_bank_r;
            rd_data_r  <= rd_en ? mem_r[rd_bank_r][rd_addr] : 8'd0;
        end
    end

    // Bank storage; contents are only meaningful once a bank is marked full.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[wr_bank_r][wr_idx_r] <= wr_data;
        end
    end

    assign wr_ready = wr_ready_r;
    assign rd_data  = rd_data_r;
    assign rd_full  = full_r[rd_bank_r];

endmodule

// File: rtl/fc_frame_scheduler.sv
// Frame-level sequencer in front of the FC/argmax unit.
// Collects feature bytes into a ping-pong buffer, streams each full frame to
// the FC unit, captures the returned logits and class, holds the result for
// the host and flags a sticky error if the FC unit does not answer in time.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   feat_data/valid/ready           upstream feature byte handshake
//   fc_in_data/valid                registered byte stream to the FC unit
//   fc_out_data/valid               logits from the FC unit, index order
//   fc_class/fc_class_valid         argmax class, one-cycle completion pulse
//   res_valid/res_ready/res_class   result held for the host
//   res_logit_idx/res_logit         combinational logit read, 0 when out of range
//   frame_cnt                       frames completed (wrapping)
//   err_timeout                     sticky watchdog error
module fc_frame_scheduler
    import fc_sched_pkg::*;
#(
    parameter int IN_DIM  = IN_DIM_DEF,
    parameter int OUT_DIM = OUT_DIM_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  feat_data,
    input  logic        feat_valid,
    output logic        feat_ready,
    output logic [7:0]  fc_in_data,
    output logic        fc_in_valid,
    input  logic [31:0] fc_out_data,
    input  logic        fc_out_valid,
    input  logic [3:0]  fc_class,
    input  logic        fc_class_valid,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_class,
    input  logic [3:0]  res_logit_idx,
    output logic [31:0] res_logit,
    output logic [15:0] frame_cnt,
    output logic        err_timeout
);

    localparam int IDX_W = $clog2(IN_DIM);
    localparam int LG_W  = $clog2(OUT_DIM + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    sched_state_t     state_r;
    sched_state_t     state_nxt_s;
    logic [IDX_W-1:0] rd_idx_r;
    logic [IDX_W-1:0] rd_idx_nxt_s;
    logic [IDX_W-1:0] rd_addr_s;
    logic             rd_en_s;
    logic             rd_free_s;
    logic             rd_full_s;
    logic [LG_W-1:0]  lg_idx_r;
    logic [LG_W-1:0]  lg_idx_nxt_s;
    logic             lg_we_s;
    logic [WD_W-1:0]  wd_r;
    logic [WD_W-1:0]  wd_nxt_s;
    logic [31:0]      logit_r [OUT_DIM];
    logic             res_valid_r;
    logic             res_valid_nxt_s;
    logic [3:0]       res_class_r;
    logic [3:0]       res_class_nxt_s;
    logic [15:0]      frame_cnt_r;
    logic [15:0]      frame_cnt_nxt_s;
    logic             err_r;
    logic             err_nxt_s;
    logic             fc_in_valid_r;
    logic [31:0]      res_logit_s;

    fc_pingpong_buf #(
        .IN_DIM (IN_DIM)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (feat_valid),
        .wr_data  (feat_data),
        .wr_ready (feat_ready),
        .rd_en    (rd_en_s),
        .rd_addr  (rd_addr_s),
        .rd_data  (fc_in_data),
        .rd_full  (rd_full_s),
        .rd_free  (rd_free_s)
    );

    // Control FSM: next state, stream addressing, capture and watchdog.
    always_comb begin
        state_nxt_s     = state_r;
        rd_en_s         = 1'b0;
        rd_addr_s       = rd_idx_r;
        rd_idx_nxt_s    = rd_idx_r;
        rd_free_s       = 1'b0;
        lg_we_s         = 1'b0;
        lg_idx_nxt_s    = lg_idx_r;
        wd_nxt_s        = wd_r;
        res_valid_nxt_s = res_valid_r;
        res_class_nxt_s = res_class_r;
        frame_cnt_nxt_s = frame_cnt_r;
        err_nxt_s       = err_r;
        case (state_r)
            S_IDLE: begin
                // Byte 0 is fetched on the transition so fc_in_valid rises
                // the cycle after the full bank is seen.
                if (rd_full_s) begin
                    rd_en_s      = 1'b1;
                    rd_addr_s    = IDX_W'(0);
                    rd_idx_nxt_s = IDX_W'(1);
                    state_nxt_s  = S_STREAM;
                end else begin
                    state_nxt_s  = S_IDLE;
                end
            end
            S_STREAM: begin
                rd_en_s   = 1'b1;
                rd_addr_s = rd_idx_r;
                if (rd_idx_r == IDX_W'(IN_DIM - 1)) begin
                    // Last byte is already captured into rd_data this edge,
                    // so the bank can be released immediately.
                    rd_idx_nxt_s = IDX_W'(0);
                    rd_free_s    = 1'b1;
                    wd_nxt_s     = WD_W'(0);
                    state_nxt_s  = S_WAIT;
                end else begin
                    rd_idx_nxt_s = rd_idx_r + IDX_W'(1);
                end
            end
            S_WAIT: begin
                if (fc_out_valid && (lg_idx_r < LG_W'(OUT_DIM))) begin
                    lg_we_s      = 1'b1;
                    lg_idx_nxt_s = lg_idx_r + LG_W'(1);
                end else begin
                    lg_we_s      = 1'b0;
                end
                // A completion in the same cycle as the watchdog limit wins.
                if (fc_class_valid) begin
                    res_class_nxt_s = fc_class;
                    res_valid_nxt_s = 1'b1;
                    frame_cnt_nxt_s = frame_cnt_r + 16'd1;
                    state_nxt_s     = S_HOLD;
                end else if (wd_r == WD_W'(TIMEOUT - 1)) begin
                    err_nxt_s       = 1'b1;
                    res_valid_nxt_s = 1'b1;
                    state_nxt_s     = S_HOLD;
                end else begin
                    wd_nxt_s        = wd_r + WD_W'(1);
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_nxt_s = 1'b0;
                    lg_idx_nxt_s    = LG_W'(0);
                    state_nxt_s     = S_IDLE;
                end else begin
                    state_nxt_s     = S_HOLD;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // FSM state, counters and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            rd_idx_r      <= IDX_W'(0);
            lg_idx_r      <= LG_W'(0);
            wd_r          <= WD_W'(0);
            res_valid_r   <= 1'b0;
            res_class_r   <= 4'd0;
            frame_cnt_r   <= 16'd0;
            err_r         <= 1'b0;
            fc_in_valid_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            rd_idx_r      <= rd_idx_nxt_s;
            lg_idx_r      <= lg_idx_nxt_s;
            wd_r          <= wd_nxt_s;
            res_valid_r   <= res_valid_nxt_s;
            res_class_r   <= res_class_nxt_s;
            frame_cnt_r   <= frame_cnt_nxt_s;
            err_r         <= err_nxt_s;
            fc_in_valid_r <= rd_en_s;
        end
    end

    // Logit capture, stored unmodified in index order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_DIM; i++) begin
                logit_r[i] <= 32'd0;
            end
        end else if (lg_we_s) begin
            logit_r[lg_idx_r] <= fc_out_data;
        end
    end

    // Host logit read port; out-of-range indices read as zero.
    always_comb begin
        res_logit_s = 32'd0;
        if (int'(res_logit_idx) < OUT_DIM) begin
            res_logit_s = logit_r[res_logit_idx];
        end else begin
            res_logit_s = 32'd0;
        end
    end

    assign fc_in_valid = fc_in_valid_r;
    assign res_valid   = res_valid_r;
    assign res_class   = res_class_r;
    assign res_logit   = res_logit_s;
    assign frame_cnt   = frame_cnt_r;
    assign err_timeout = err_r;

endmodule

// File: tb/tb_fc_frame_scheduler.sv
// Directed self-checking bench for fc_frame_scheduler (default parameters).
module tb_fc_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  feat_data = 8'd0;
    logic        feat_valid = 1'b0;
    logic        feat_ready;
    logic [7:0]  fc_in_data;
    logic        fc_in_valid;
    logic [31:0] fc_out_data = 32'd0;
    logic        fc_out_valid = 1'b0;
    logic [3:0]  fc_class = 4'd0;
    logic        fc_class_valid = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [3:0]  res_class;
    logic [3:0]  res_logit_idx = 4'd0;
    logic [31:0] res_logit;
    logic [15:0] frame_cnt;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    logic [31:0] lg_tab [10] = '{32'd5, 32'hFFFF_FFFD, 32'd0, 32'd9, 32'd1,
                                 32'd2, 32'hFFFF_FFF9, 32'd100, 32'd4, 32'd6};

    always #5 clk = ~clk;

    fc_frame_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .feat_data      (feat_data),
        .feat_valid     (feat_valid),
        .feat_ready     (feat_ready),
        .fc_in_data     (fc_in_data),
        .fc_in_valid    (fc_in_valid),
        .fc_out_data    (fc_out_data),
        .fc_out_valid   (fc_out_valid),
        .fc_class       (fc_class),
        .fc_class_valid (fc_class_valid),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_class      (res_class),
        .res_logit_idx  (res_logit_idx),
        .res_logit      (res_logit),
        .frame_cnt      (frame_cnt),
        .err_timeout    (err_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte and wait (bounded) until it is taken.
    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        feat_valid = 1'b1;
        feat_data  = d;
        while (feat_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("feat_ready_timeout", 32'(feat_ready), 32'd1);
        tick();
        feat_valid = 1'b0;
    endtask

    // Called in the cycle right after the last byte of a frame was accepted.
    task automatic stream_expect(input int base);
        check("stream_lead_gap", 32'(fc_in_valid), 32'd0);
        tick();
        for (int i = 0; i < 32; i++) begin
            check("stream_valid", 32'(fc_in_valid), 32'd1);
            check("stream_data", 32'(fc_in_data), 32'((base + i) & 255));
            tick();
        end
        check("stream_trail", 32'(fc_in_valid), 32'd0);
    endtask

    task automatic logit_expect(input logic [3:0] idx, input logic [31:0] exp, input string tag);
        res_logit_idx = idx;
        #1;
        check(tag, res_logit, exp);
    endtask

    task automatic host_ack();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        // Reset state
        #12 rst_n = 1'b1;
        #1;
        check("rst_feat_ready_first", 32'(feat_ready), 32'd0);
        check("rst_fc_in_valid", 32'(fc_in_valid), 32'd0);
        check("rst_fc_in_data", 32'(fc_in_data), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_class", 32'(res_class), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        logit_expect(4'd3, 32'd0, "rst_logit");
        tick();
        check("feat_ready_after_rst", 32'(feat_ready), 32'd1);

        // 1: single frame 0..31, continuous
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        stream_expect(0);

        // 2: logit capture and class result
        for (int k = 0; k < 10; k++) begin
            fc_out_valid = 1'b1;
            fc_out_data  = lg_tab[k];
            tick();
        end
        fc_out_valid   = 1'b0;
        fc_class_valid = 1'b1;
        fc_class       = 4'd7;
        tick();
        fc_class_valid = 1'b0;
        check("f1_res_valid", 32'(res_valid), 32'd1);
        check("f1_res_class", 32'(res_class), 32'd7);
        check("f1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("f1_err", 32'(err_timeout), 32'd0);
        logit_expect(4'd7, 32'd100, "f1_logit7");
        logit_expect(4'd1, 32'hFFFF_FFFD, "f1_logit1");
        logit_expect(4'd6, 32'hFFFF_FFF9, "f1_logit6");
        logit_expect(4'd9, 32'd6, "f1_logit9");
        logit_expect(4'd12, 32'd0, "f1_logit12");

        // 3: fill both banks while the result is held
        for (int i = 0; i < 64; i++) send_byte(8'(100 + i));
        check("bp_feat_ready_low", 32'(feat_ready), 32'd0);
        feat_valid = 1'b1;
        feat_data  = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold_ready", 32'(feat_ready), 32'd0);
            check("bp_no_stream", 32'(fc_in_valid), 32'd0);
            check("bp_res_held", 32'(res_valid), 32'd1);
        end
        feat_valid = 1'b0;
        host_ack();
        check("f1_ack_res_valid", 32'(res_valid), 32'd0);
        stream_expect(100);

        // Logit 10 coincides with the class pulse
        for (int k = 0; k < 9; k++) begin
            fc_out_valid = 1'b1;
            fc_out_data  = 32'(11 + k);
            tick();
        end
        fc_out_data    = 32'hFFFF_FFFF;
        fc_class_valid = 1'b1;
        fc_class       = 4'd3;
        tick();
        fc_out_valid   = 1'b0;
        fc_class_valid = 1'b0;
        check("f2_res_valid", 32'(res_valid), 32'd1);
        check("f2_res_class", 32'(res_class), 32'd3);
        check("f2_frame_cnt", 32'(frame_cnt), 32'd2);
        logit_expect(4'd0, 32'd11, "f2_logit0");
        logit_expect(4'd9, 32'hFFFF_FFFF, "f2_logit9_coincide");
        host_ack();
        stream_expect(132);

        // 4: watchdog, 11 logits (the last one ignored), no class pulse
        for (int k = 0; k < 11; k++) begin
            fc_out_valid = 1'b1;
            fc_out_data  = 32'(1000 + k);
            tick();
        end
        fc_out_valid = 1'b0;
        repeat (51) tick();
        check("wd_res_valid_early", 32'(res_valid), 32'd0);
        check("wd_err_early", 32'(err_timeout), 32'd0);
        tick();
        check("wd_res_valid", 32'(res_valid), 32'd1);
        check("wd_err", 32'(err_timeout), 32'd1);
        check("wd_frame_cnt", 32'(frame_cnt), 32'd2);
        logit_expect(4'd0, 32'd1000, "wd_logit0");
        logit_expect(4'd9, 32'd1009, "wd_logit9_no_overrun");
        host_ack();
        check("wd_ack_res_valid", 32'(res_valid), 32'd0);
        check("wd_err_sticky", 32'(err_timeout), 32'd1);

        // 5: upstream gaps
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(200 + i));
            if (i != 31) tick();
        end
        stream_expect(200);
        fc_class_valid = 1'b1;
        fc_class       = 4'd5;
        tick();
        fc_class_valid = 1'b0;
        check("f4_res_class", 32'(res_class), 32'd5);
        check("f4_frame_cnt", 32'(frame_cnt), 32'd3);
        check("f4_err_sticky", 32'(err_timeout), 32'd1);
        host_ack();

        // 6: reset during byte 10 of a stream
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        check("f5_lead_gap", 32'(fc_in_valid), 32'd0);
        tick();
        for (int i = 0; i < 10; i++) tick();
        check("f5_byte10", 32'(fc_in_data), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_fc_in_valid", 32'(fc_in_valid), 32'd0);
        check("mid_rst_fc_in_data", 32'(fc_in_data), 32'd0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("mid_rst_err", 32'(err_timeout), 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_res_class", 32'(res_class), 32'd0);
        check("mid_rst_feat_ready", 32'(feat_ready), 32'd0);
        logit_expect(4'd0, 32'd0, "mid_rst_logit0");
        #2 rst_n = 1'b1;
        #1;
        check("rel_feat_ready_first", 32'(feat_ready), 32'd0);
        tick();
        check("rel_feat_ready", 32'(feat_ready), 32'd1);
        check("rel_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rel_no_stream", 32'(fc_in_valid), 32'd0);
        tick();
        check("rel_no_stream2", 32'(fc_in_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
